pmul_result_serializer: RTL and testbench

//  Downstream consumer of the pipelined 96-bit multiplier result stream.
//  - Captures each {in_valid, in_data} product into a small FIFO.
//  - Replays each product as IN_W/OUT_W narrow beats, MSB first, over a valid/ready interface.
//  - The multiplier has no backpressure: a word arriving while the FIFO is full is dropped and flagged.

---
 rtl/pmul_result_serializer.sv | 80 ++++++++
 tb/tb_pmul_result_serializer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pmul_result_serializer.sv
// Buffers 96-bit multiplier products in a small FIFO and replays each as MSB-first narrow beats.
// Optional out_parity port (even parity of the current beat) when PMUL_SER_PARITY_EN is defined.
module pmul_result_serializer #(
  parameter int DEPTH = 4,
  parameter int OUT_W = 16,
  parameter int IN_W  = 96,
  localparam int BEATS = IN_W / OUT_W,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
  output logic             out_last,
  output logic [CW-1:0]    fifo_count,
  output logic             overflow
`ifdef PMUL_SER_PARITY_EN
  , output logic           out_parity
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

  // Word stored as beat slices; slice BEATS-1 is the MSB end, sent first.
  typedef logic [BEATS-1:0][OUT_W-1:0] word_t;

  word_t          mem [DEPTH];
  logic [PW-1:0]  wptr, rptr;
  logic [CW-1:0]  cnt, cnt_n;
  logic [BW-1:0]  beat;
  logic [0:0]     state, state_n;
  logic           full, xfer, pop_last, push;

  assign full     = (cnt == FULL_CNT);
  assign out_valid = (state == SEND);
  assign out_last  = out_valid && (beat == LAST_BEAT);
  assign xfer      = out_valid && out_ready;
  assign pop_last  = xfer && out_last;
  // Freeing the head slot on its final beat makes room for a word arriving that same cycle.
  assign push      = in_valid && (!full || pop_last);
  assign cnt_n     = cnt + CW'(push) - CW'(pop_last);
  assign state_n   = (cnt_n != '0) ? SEND : IDLE;
  assign out_data  = out_valid ? mem[rptr][LAST_BEAT - beat] : '0;
  assign fifo_count = cnt;

`ifdef PMUL_SER_PARITY_EN
  assign out_parity = ^out_data;
`endif

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      wptr     <= '0;
      rptr     <= '0;
      beat     <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (push)     wptr <= wptr + 1'b1;
      if (pop_last) rptr <= rptr + 1'b1;
      if (xfer)     beat <= out_last ? '0 : beat + 1'b1;
      if (in_valid && full && !pop_last) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pmul_result_serializer.sv
// Directed bench for pmul_result_serializer: per-cycle vector table plus overflow,
// push-on-final-pop and mid-word reset sequences.
module tb_pmul_result_serializer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [95:0] in_data;
  logic        out_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_last;
  logic [2:0]  fifo_count;
  logic        overflow;
`ifdef PMUL_SER_PARITY_EN
  logic        out_parity;
`endif

  pmul_result_serializer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_last(out_last), .fifo_count(fifo_count), .overflow(overflow)
`ifdef PMUL_SER_PARITY_EN
    , .out_parity(out_parity)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [95:0] d;
    logic        rdy;
    logic        ev;
    logic [15:0] ed;
    logic        el;
    logic [2:0]  ec;
  } vec_t;

  vec_t        tbl [$];
  logic [15:0] expq [$];
  int          ncmp = 0;
  int          nfail = 0;

  localparam logic [95:0] WT1 = 96'h0001_0002_0003_0004_0005_0006;
  localparam logic [95:0] WP  = 96'h0007_0003_0000_FFFF_0001_8000;

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic iv, input logic [95:0] d, input logic rdy,
                     input logic ev, input logic [15:0] ed, input logic el, input logic [2:0] ec);
    vec_t v;
    v.iv = iv; v.d = d; v.rdy = rdy; v.ev = ev; v.ed = ed; v.el = el; v.ec = ec;
    tbl.push_back(v);
  endtask

  // Word i: beat k = 16'h1000*i + k + 1
  function automatic logic [95:0] mkword(input int i);
    logic [95:0] w;
    for (int k = 0; k < 6; k++) w[95-16*k -: 16] = 16'(32'h1000 * i + k + 1);
    return w;
  endfunction

  task automatic push_beats(input int i);
    logic [95:0] w;
    w = mkword(i);
    for (int k = 0; k < 6; k++) expq.push_back(w[95-16*k -: 16]);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", out_valid, 0);
    chk("reset out_data", out_data, 0);
    chk("reset out_last", out_last, 0);
    chk("reset fifo_count", fifo_count, 0);
    chk("reset overflow", overflow, 0);
    rst_n = 1'b1;
  endtask

  // Drains nbeats beats against expq; optionally pushes word 6 on the first final-beat transfer.
  task automatic drain(input int nbeats, input bit inject);
    int idx = 0;
    int cyc = 0;
    bit injected = 0;
    bit post_chk = 0;
    logic [15:0] e;
    out_ready = 1'b1;
    while (idx < nbeats && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (out_valid) begin
        e = (expq.size() != 0) ? expq.pop_front() : 16'hxxxx;
        chk($sformatf("drain beat%0d data", idx), out_data, e);
        chk($sformatf("drain beat%0d last", idx), out_last, (idx % 6) == 5);
        idx++;
        if (inject && !injected && out_last) begin
          in_valid = 1'b1; in_data = mkword(6); injected = 1; post_chk = 1;
        end
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (post_chk) begin
        chk("push-on-pop fifo_count", fifo_count, 4);
        chk("push-on-pop overflow", overflow, 0);
        post_chk = 0;
      end
    end
    chk("drain beat count", idx, nbeats);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1);
  end

  initial begin
    // T1: single word, 1-cycle latency, MSB-first beats
    add(1, WT1, 1, 0, 16'h0000, 0, 0);
    add(0, '0,  1, 1, 16'h0001, 0, 1);
    add(0, '0,  1, 1, 16'h0002, 0, 1);
    add(0, '0,  1, 1, 16'h0003, 0, 1);
    add(0, '0,  1, 1, 16'h0004, 0, 1);
    add(0, '0,  1, 1, 16'h0005, 0, 1);
    add(0, '0,  1, 1, 16'h0006, 1, 1);
    add(0, '0,  1, 0, 16'h0000, 0, 0);
    // T2: ready toggling 1,0,1,0 -- each stalled beat held
    add(1, WT1, 0, 0, 16'h0000, 0, 0);
    add(0, '0,  1, 1, 16'h0001, 0, 1);
    add(0, '0,  0, 1, 16'h0002, 0, 1);
    add(0, '0,  1, 1, 16'h0002, 0, 1);
    add(0, '0,  0, 1, 16'h0003, 0, 1);
    add(0, '0,  1, 1, 16'h0003, 0, 1);
    add(0, '0,  0, 1, 16'h0004, 0, 1);
    add(0, '0,  1, 1, 16'h0004, 0, 1);
    add(0, '0,  0, 1, 16'h0005, 0, 1);
    add(0, '0,  1, 1, 16'h0005, 0, 1);
    add(0, '0,  0, 1, 16'h0006, 1, 1);
    add(0, '0,  1, 1, 16'h0006, 1, 1);
    add(0, '0,  1, 0, 16'h0000, 0, 0);
    // Back-to-back: zero product then parity word, no bubble between them
    add(1, '0,  1, 0, 16'h0000, 0, 0);
    add(1, WP,  1, 1, 16'h0000, 0, 1);
    add(0, '0,  1, 1, 16'h0000, 0, 2);
    add(0, '0,  1, 1, 16'h0000, 0, 2);
    add(0, '0,  1, 1, 16'h0000, 0, 2);
    add(0, '0,  1, 1, 16'h0000, 0, 2);
    add(0, '0,  1, 1, 16'h0000, 1, 2);
    add(0, '0,  1, 1, 16'h0007, 0, 1);
    add(0, '0,  1, 1, 16'h0003, 0, 1);
    add(0, '0,  1, 1, 16'h0000, 0, 1);
    add(0, '0,  1, 1, 16'hFFFF, 0, 1);
    add(0, '0,  1, 1, 16'h0001, 0, 1);
    add(0, '0,  1, 1, 16'h8000, 1, 1);
    add(0, '0,  1, 0, 16'h0000, 0, 0);

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      in_valid = tbl[i].iv; in_data = tbl[i].d; out_ready = tbl[i].rdy;
      @(negedge clk);
      chk($sformatf("row%0d out_valid", i), out_valid, tbl[i].ev);
      chk($sformatf("row%0d out_data", i), out_data, tbl[i].ed);
      chk($sformatf("row%0d out_last", i), out_last, tbl[i].el);
      chk($sformatf("row%0d fifo_count", i), fifo_count, tbl[i].ec);
      chk($sformatf("row%0d overflow", i), overflow, 0);
`ifdef PMUL_SER_PARITY_EN
      if (tbl[i].ev) chk($sformatf("row%0d out_parity", i), out_parity, ^tbl[i].ed);
`endif
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;

    // T3: overflow with ready low, W5 dropped
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      in_valid = 1'b1; in_data = mkword(i);
      @(posedge clk);
      #1;
      if (i == 4) chk("T3 overflow before W5", overflow, 0);
    end
    in_valid = 1'b0;
    chk("T3 fifo_count full", fifo_count, 4);
    chk("T3 overflow set", overflow, 1);
    expq.delete();
    for (int i = 1; i <= 4; i++) push_beats(i);
    drain(24, 0);
    @(negedge clk);
    chk("T3 idle after drain", out_valid, 0);
    chk("T3 fifo_count empty", fifo_count, 0);
    chk("T3 overflow sticky", overflow, 1);
    @(posedge clk);
    #1;

    // T5: reset after 3 beats of a word (overflow still set from T3)
    out_ready = 1'b1; in_valid = 1'b1; in_data = mkword(7);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("T5 mid-word beat", out_data, 16'h7004);
    rst_n = 1'b0;
    #1;
    chk("T5 reset out_valid", out_valid, 0);
    chk("T5 reset fifo_count", fifo_count, 0);
    chk("T5 reset overflow", overflow, 0);
    chk("T5 reset out_data", out_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b1; in_data = mkword(8);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    expq.delete();
    push_beats(8);
    drain(6, 0);

    // T4: full FIFO, push lands on the final-beat pop
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_data = mkword(i);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("T4 fifo_count full", fifo_count, 4);
    expq.delete();
    for (int i = 1; i <= 4; i++) push_beats(i);
    push_beats(6);
    drain(30, 1);
    @(negedge clk);
    chk("T4 idle after drain", out_valid, 0);
    chk("T4 fifo_count empty", fifo_count, 0);
    chk("T4 overflow clear", overflow, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
